// File: rtl/sync_ram.sv
// sync_ram: single-port, single-clock register-file RAM with registered,
// write-first read data and a synchronous clear of every word on reset.
// Storage is plain registers so the whole array can be cleared in one edge.

module sync_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear-or-access: reset wipes all words and the read register, otherwise
  // one write and/or read per edge, with new write data forwarded to rd_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else if (wr) begin
      mem[addr] <= wr_data;
      rd_data   <= wr_data;
    end else begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: tb/tb_sync_ram.sv
// tb_sync_ram: directed self-checking bench for sync_ram (8 x 8 default).
// Inputs change 1ns after each rising edge; rd_data is checked there too.

module tb_sync_ram;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic [2:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;

  int checks;
  int failures;

  sync_ram #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  // Free-running 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst_n   = 1'b0;
    wr      = 1'b1;
    addr    = 3'd0;
    wr_data = 8'hFF;
    for (int e = 0; e < 2; e++) begin
      addr = 3'(e);
      step();
      checks++;
      if (rd_data !== 8'h00) begin
        failures++;
        $display("[TB] FAIL reset_hold edge=%0d rd_data=%h expected=00", e, rd_data);
      end
    end
    rst_n = 1'b1;
    wr    = 1'b0;
    exp   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      step();
      checks++;
      if (rd_data !== exp) begin
        failures++;
        $display("[TB] FAIL reset_clear addr=%0d rd_data=%h expected=%h", i, rd_data, exp);
      end
    end
  endtask

  task automatic test_basic();
    wr = 1'b1; addr = 3'd0; wr_data = 8'hCC;
    step();
    checks++;
    if (rd_data !== 8'hCC) begin
      failures++;
      $display("[TB] FAIL basic_write_fwd rd_data=%h expected=cc", rd_data);
    end
    wr = 1'b0; addr = 3'd0; wr_data = 8'h00;
    step();
    checks++;
    if (rd_data !== 8'hCC) begin
      failures++;
      $display("[TB] FAIL basic_read0 rd_data=%h expected=cc", rd_data);
    end
    addr = 3'd1;
    step();
    checks++;
    if (rd_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL basic_read1 rd_data=%h expected=00", rd_data);
    end
  endtask

  task automatic test_write_first();
    wr = 1'b1; addr = 3'd1; wr_data = 8'h5A;
    step();
    checks++;
    if (rd_data !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL wf_first_write rd_data=%h expected=5a", rd_data);
    end
    wr_data = 8'h00;
    step();
    checks++;
    if (rd_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL wf_overwrite rd_data=%h expected=00", rd_data);
    end
    wr = 1'b0; addr = 3'd0; wr_data = 8'h33;
    step();
    checks++;
    if (rd_data !== 8'hCC) begin
      failures++;
      $display("[TB] FAIL wf_no_alias rd_data=%h expected=cc", rd_data);
    end
    addr = 3'd1;
    step();
    checks++;
    if (rd_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL wf_last_wins rd_data=%h expected=00", rd_data);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr    = 3'(i);
      wr_data = 8'h10 + 8'(i);
      step();
    end
    wr = 1'b0;
    wr_data = 8'hEE;
    for (int i = 7; i >= 0; i--) begin
      addr = 3'(i);
      exp  = 8'h10 + 8'(i);
      step();
      checks++;
      if (rd_data !== exp) begin
        failures++;
        $display("[TB] FAIL sweep addr=%0d rd_data=%h expected=%h", i, rd_data, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; wr = 1'b1; addr = 3'd5; wr_data = 8'hAA;
    step();
    checks++;
    if (rd_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL mid_reset_rd rd_data=%h expected=00", rd_data);
    end
    rst_n = 1'b1; wr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      addr = 3'(7 - k);
      step();
      checks++;
      if (rd_data !== 8'h00) begin
        failures++;
        $display("[TB] FAIL mid_reset_clear addr=%0d rd_data=%h expected=00", 7 - k, rd_data);
      end
    end
  endtask

  task automatic test_hold();
    wr = 1'b1; addr = 3'd2; wr_data = 8'h77;
    step();
    wr = 1'b0; addr = 3'd6; wr_data = 8'h00;
    step();
    checks++;
    if (rd_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL hold_setup rd_data=%h expected=00", rd_data);
    end
    addr = 3'd2;
    step();
    checks++;
    if (rd_data !== 8'h77) begin
      failures++;
      $display("[TB] FAIL hold_read rd_data=%h expected=77", rd_data);
    end
    addr = 3'd3;
    #2;
    checks++;
    if (rd_data !== 8'h77) begin
      failures++;
      $display("[TB] FAIL hold_addr_change rd_data=%h expected=77", rd_data);
    end
    addr = 3'd4;
    #1;
    checks++;
    if (rd_data !== 8'h77) begin
      failures++;
      $display("[TB] FAIL hold_addr_change2 rd_data=%h expected=77", rd_data);
    end
    step();
    checks++;
    if (rd_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL hold_next_edge rd_data=%h expected=00", rd_data);
    end
  endtask

  // Run every scenario in order, then print the summary
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    wr       = 1'b0;
    addr     = 3'd0;
    wr_data  = 8'h00;
    #2;
    test_reset();
    test_basic();
    test_write_first();
    test_sweep();
    test_reset_mid();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
